// File: rtl/mem_wb_unit_pkg.sv
// mem_wb_unit_pkg
// Shared definitions for the MEM/WB back end of the dual-issue pipeline:
// register-index width, the link register number, the memory-serialisation
// FSM encoding and a small helper that decides whether a slot mispredicted.
package mem_wb_unit_pkg;

  // Width of a register index in a slot bundle.
  localparam int REG_W = 5;

  // Register written by jal (link register).
  localparam logic [REG_W-1:0] LINK_REG = 5'd31;

  // RUN: normal flow, both slots retire together.
  // SPLIT: slot 1 already retired, slot 2 now owns the memory port.
  typedef enum logic {
    RUN   = 1'b0,
    SPLIT = 1'b1
  } mem_state_e;

  // A live branch whose resolved direction differs from the prediction.
  function automatic logic mispredicts(input logic live, input logic branch,
                                       input logic taken, input logic pred);
    return live & branch & (taken ^ pred);
  endfunction

endpackage

// File: rtl/mem_wb_slot_reg.sv
// mem_wb_slot_reg
// One slot's MEM/WB pipeline register plus the write-back data select.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   commit            slot really retires on this edge (live and its turn)
//   alu_res, return_addr, mem_to_reg, reg_write_en, jal, dest_reg
//                     MEM-stage slot fields captured on every edge
//   dmem_rdata        memory read data, valid during the WB cycle
//   write_data        selected write-back value (jal link / load / ALU)
//   alu_res_wb, write_reg, reg_write, jal_wb
//                     registered WB-stage fields
module mem_wb_slot_reg
  import mem_wb_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [PC_W-1:0]   return_addr,
  input  logic              mem_to_reg,
  input  logic              reg_write_en,
  input  logic              jal,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] alu_res_wb,
  output logic [REG_W-1:0]  write_reg,
  output logic              reg_write,
  output logic              jal_wb
);

  logic [PC_W-1:0] return_addr_q;
  logic            mem_to_reg_q;

  // Data fields are captured every edge; only the write enable and the jal
  // flag are qualified by commit, so a slot that does not retire this edge
  // leaves no architectural effect in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res_wb    <= '0;
      return_addr_q <= '0;
      mem_to_reg_q  <= 1'b0;
      write_reg     <= '0;
      reg_write     <= 1'b0;
      jal_wb        <= 1'b0;
    end else begin
      alu_res_wb    <= alu_res;
      return_addr_q <= return_addr;
      mem_to_reg_q  <= mem_to_reg;
      write_reg     <= dest_reg;
      reg_write     <= commit & reg_write_en;
      jal_wb        <= commit & jal;
    end
  end

  // Load data arrives from memory during WB, so it is selected here rather
  // than registered. The jal link value takes precedence.
  always_comb begin
    write_data = alu_res_wb;
    if (jal_wb) begin
      write_data = {{(DATA_W-PC_W){1'b0}}, return_addr_q};
    end else if (mem_to_reg_q) begin
      write_data = dmem_rdata;
    end
  end

endmodule

// File: rtl/mem_wb_unit.sv
// mem_wb_unit
// Back end of the dual-issue pipeline. Takes both EX/MEM slot bundles,
// drives the single data-memory port (serialising the slots when both need
// it), holds the MEM/WB registers and resolves branch mispredictions.
// Slot 1 is always the older instruction.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   *1_MEM / *2_MEM               EX/MEM slot bundles
//   dmem_rdata                    read data, valid the cycle after dmem_re
//   dmem_addr/wdata/we/re         shared data-memory port
//   mem_stall                     freezes upstream and EX/MEM registers
//   aluRes{1,2}_MEM_fwd           MEM-stage forwarding values
//   *_WB                          write-back outputs per slot
//   correct_en, flush_IFID, flush_IDEX, correction
//                                 branch correction to the front pipe
module mem_wb_unit
  import mem_wb_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PC_W    = 10,
  parameter int DMEM_AW = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  aluRes1_MEM,
  input  logic [DATA_W-1:0]  aluRes2_MEM,
  input  logic [DATA_W-1:0]  forwardBRes1_MEM,
  input  logic [DATA_W-1:0]  forwardBRes2_MEM,
  input  logic               MemReadEn1_MEM,
  input  logic               MemReadEn2_MEM,
  input  logic               MemWriteEn1_MEM,
  input  logic               MemWriteEn2_MEM,
  input  logic               MemtoReg1_MEM,
  input  logic               MemtoReg2_MEM,
  input  logic               RegWriteEn1_MEM,
  input  logic               RegWriteEn2_MEM,
  input  logic               jal1_MEM,
  input  logic               jal2_MEM,
  input  logic               Branch1_MEM,
  input  logic               Branch2_MEM,
  input  logic               taken1_MEM,
  input  logic               taken2_MEM,
  input  logic               pred1_MEM,
  input  logic               pred2_MEM,
  input  logic [REG_W-1:0]   DestReg1_MEM,
  input  logic [REG_W-1:0]   DestReg2_MEM,
  input  logic [PC_W-1:0]    return_addr1_MEM,
  input  logic [PC_W-1:0]    return_addr2_MEM,
  input  logic [PC_W-1:0]    target1_MEM,
  input  logic [PC_W-1:0]    target2_MEM,
  input  logic [DATA_W-1:0]  dmem_rdata,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  output logic               dmem_re,
  output logic               mem_stall,
  output logic [DATA_W-1:0]  aluRes1_MEM_fwd,
  output logic [DATA_W-1:0]  aluRes2_MEM_fwd,
  output logic [DATA_W-1:0]  writeData1_WB,
  output logic [DATA_W-1:0]  writeData2_WB,
  output logic [DATA_W-1:0]  aluRes1_WB,
  output logic [DATA_W-1:0]  aluRes2_WB,
  output logic [REG_W-1:0]   writeReg1_WB,
  output logic [REG_W-1:0]   writeReg2_WB,
  output logic               regWrite1_WB,
  output logic               regWrite2_WB,
  output logic               jal1_WB,
  output logic               jal2_WB,
  output logic               correct_en,
  output logic               flush_IFID,
  output logic               flush_IDEX,
  output logic [PC_W-1:0]    correction
);

  mem_state_e state_q;
  logic       squash_q;

  logic live1, live2;
  logic mem1, mem2;
  logic mis1, mis2;
  logic split_start;
  logic commit1, commit2;

  // Slot qualification. During SPLIT slot 1 has already retired, so only
  // slot 2 is considered. A slot 1 mispredict kills slot 2 outright, which
  // also prevents a SPLIT. When a SPLIT is about to start, slot 2 is only
  // evaluated (branch and retirement) in the SPLIT cycle, so its branch
  // outcome is not acted on twice.
  always_comb begin
    live1       = ~squash_q & (state_q == RUN);
    mis1        = mispredicts(live1, Branch1_MEM, taken1_MEM, pred1_MEM);
    live2       = ~squash_q & ~mis1;
    mem1        = live1 & (MemReadEn1_MEM | MemWriteEn1_MEM);
    mem2        = live2 & (MemReadEn2_MEM | MemWriteEn2_MEM);
    split_start = (state_q == RUN) & mem1 & mem2;
    mis2        = mispredicts(live2 & ~split_start, Branch2_MEM, taken2_MEM, pred2_MEM);
    commit1     = live1;
    commit2     = live2 & ~split_start;
  end

  // Memory port: the older slot wins whenever it is a mem op; in SPLIT slot 1
  // is not live so slot 2 drives the port from the held upstream inputs.
  // Strobes are masked during reset so a reset in SPLIT aborts slot 2's write.
  always_comb begin
    if (mem1) begin
      dmem_addr  = aluRes1_MEM[DMEM_AW-1:0];
      dmem_wdata = forwardBRes1_MEM;
      dmem_we    = MemWriteEn1_MEM & ~rst;
      dmem_re    = MemReadEn1_MEM & ~rst;
    end else begin
      dmem_addr  = aluRes2_MEM[DMEM_AW-1:0];
      dmem_wdata = forwardBRes2_MEM;
      dmem_we    = mem2 & MemWriteEn2_MEM & ~rst;
      dmem_re    = mem2 & MemReadEn2_MEM & ~rst;
    end
  end

  // Stall, branch correction and forwarding. Slot 1 has priority when
  // choosing the correction target.
  always_comb begin
    mem_stall       = split_start & ~rst;
    correct_en      = (mis1 | mis2) & ~rst;
    flush_IFID      = correct_en;
    flush_IDEX      = correct_en;
    correction      = '0;
    if (mis1) begin
      correction = taken1_MEM ? target1_MEM : return_addr1_MEM;
    end else if (mis2) begin
      correction = taken2_MEM ? target2_MEM : return_addr2_MEM;
    end
    aluRes1_MEM_fwd = aluRes1_MEM;
    aluRes2_MEM_fwd = aluRes2_MEM;
  end

  // Serialisation FSM and the wrong-path squash flag. Mispredicts never
  // coincide with a stall, so the cycle after a mispredict is always an
  // accepted one and the squash lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      squash_q <= 1'b0;
    end else begin
      state_q  <= split_start ? SPLIT : RUN;
      squash_q <= mis1 | mis2;
    end
  end

  mem_wb_slot_reg #(.DATA_W(DATA_W), .PC_W(PC_W)) u_slot1 (
    .clk          (clk),
    .rst          (rst),
    .commit       (commit1),
    .alu_res      (aluRes1_MEM),
    .return_addr  (return_addr1_MEM),
    .mem_to_reg   (MemtoReg1_MEM),
    .reg_write_en (RegWriteEn1_MEM),
    .jal          (jal1_MEM),
    .dest_reg     (DestReg1_MEM),
    .dmem_rdata   (dmem_rdata),
    .write_data   (writeData1_WB),
    .alu_res_wb   (aluRes1_WB),
    .write_reg    (writeReg1_WB),
    .reg_write    (regWrite1_WB),
    .jal_wb       (jal1_WB)
  );

  mem_wb_slot_reg #(.DATA_W(DATA_W), .PC_W(PC_W)) u_slot2 (
    .clk          (clk),
    .rst          (rst),
    .commit       (commit2),
    .alu_res      (aluRes2_MEM),
    .return_addr  (return_addr2_MEM),
    .mem_to_reg   (MemtoReg2_MEM),
    .reg_write_en (RegWriteEn2_MEM),
    .jal          (jal2_MEM),
    .dest_reg     (DestReg2_MEM),
    .dmem_rdata   (dmem_rdata),
    .write_data   (writeData2_WB),
    .alu_res_wb   (aluRes2_WB),
    .write_reg    (writeReg2_WB),
    .reg_write    (regWrite2_WB),
    .jal_wb       (jal2_WB)
  );

endmodule

// File: tb/tb_mem_wb_unit.sv
// tb_mem_wb_unit
// Directed bench for mem_wb_unit: a behavioural reference of the back end
// checked against the DUT every cycle, plus literal expectations for each
// scenario. The bench also provides the data memory.
module tb_mem_wb_unit;
  import mem_wb_unit_pkg::*;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] fb;
    logic        re, we, m2r, rw, jal, br, tk, pr;
    logic [4:0]  dest;
    logic [9:0]  ra, tgt;
  } slot_t;

  typedef struct packed {
    logic        chk;
    logic        rw;
    logic        jal;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [31:0] alu;
  } wb_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  slot_t cur1, cur2;

  logic [31:0] ram [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] rdata = '0;

  logic [9:0]  dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we, dmem_re, mem_stall;
  logic [31:0] fwd1, fwd2, wd1, wd2, alu1_wb, alu2_wb;
  logic [4:0]  wr1, wr2;
  logic        rw1, rw2, jal1_wb, jal2_wb;
  logic        correct_en, flush_IFID, flush_IDEX;
  logic [9:0]  correction;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_wb_unit dut (
    .clk(clk), .rst(rst),
    .aluRes1_MEM(cur1.alu), .aluRes2_MEM(cur2.alu),
    .forwardBRes1_MEM(cur1.fb), .forwardBRes2_MEM(cur2.fb),
    .MemReadEn1_MEM(cur1.re), .MemReadEn2_MEM(cur2.re),
    .MemWriteEn1_MEM(cur1.we), .MemWriteEn2_MEM(cur2.we),
    .MemtoReg1_MEM(cur1.m2r), .MemtoReg2_MEM(cur2.m2r),
    .RegWriteEn1_MEM(cur1.rw), .RegWriteEn2_MEM(cur2.rw),
    .jal1_MEM(cur1.jal), .jal2_MEM(cur2.jal),
    .Branch1_MEM(cur1.br), .Branch2_MEM(cur2.br),
    .taken1_MEM(cur1.tk), .taken2_MEM(cur2.tk),
    .pred1_MEM(cur1.pr), .pred2_MEM(cur2.pr),
    .DestReg1_MEM(cur1.dest), .DestReg2_MEM(cur2.dest),
    .return_addr1_MEM(cur1.ra), .return_addr2_MEM(cur2.ra),
    .target1_MEM(cur1.tgt), .target2_MEM(cur2.tgt),
    .dmem_rdata(rdata),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_re(dmem_re), .mem_stall(mem_stall),
    .aluRes1_MEM_fwd(fwd1), .aluRes2_MEM_fwd(fwd2),
    .writeData1_WB(wd1), .writeData2_WB(wd2),
    .aluRes1_WB(alu1_wb), .aluRes2_WB(alu2_wb),
    .writeReg1_WB(wr1), .writeReg2_WB(wr2),
    .regWrite1_WB(rw1), .regWrite2_WB(rw2),
    .jal1_WB(jal1_wb), .jal2_WB(jal2_wb),
    .correct_en(correct_en), .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .correction(correction)
  );

  // Data memory seen by the DUT: synchronous write, read data one cycle later.
  always @(posedge clk) begin
    if (dmem_we) ram[dmem_addr] <= dmem_wdata;
    if (dmem_re) rdata <= ram[dmem_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Instruction builders.
  function automatic slot_t nop_s();
    slot_t s = '0;
    return s;
  endfunction
  function automatic slot_t alu_s(input logic [31:0] v, input logic [4:0] d);
    slot_t s = '0;
    s.alu = v; s.rw = 1'b1; s.dest = d;
    return s;
  endfunction
  function automatic slot_t lw_s(input logic [31:0] a, input logic [4:0] d);
    slot_t s = '0;
    s.alu = a; s.re = 1'b1; s.m2r = 1'b1; s.rw = 1'b1; s.dest = d;
    return s;
  endfunction
  function automatic slot_t sw_s(input logic [31:0] a, input logic [31:0] v);
    slot_t s = '0;
    s.alu = a; s.fb = v; s.we = 1'b1;
    return s;
  endfunction
  function automatic slot_t br_s(input logic tk, input logic pr, input logic [9:0] ra, input logic [9:0] tgt);
    slot_t s = '0;
    s.br = 1'b1; s.tk = tk; s.pr = pr; s.ra = ra; s.tgt = tgt;
    return s;
  endfunction
  function automatic slot_t jal_s(input logic [9:0] ra);
    slot_t s = '0;
    s.alu = 32'h99; s.jal = 1'b1; s.rw = 1'b1; s.dest = LINK_REG; s.ra = ra;
    return s;
  endfunction

  // Reference model state: whether slot 2 of the held pair still waits for
  // memory, whether the current pair is wrong-path, and what WB must show.
  logic    m_ready = 1'b0;
  logic    m_zero  = 1'b1;
  logic    m_pend2 = 1'b0;
  logic    m_squash = 1'b0;
  wb_exp_t m_wb [2];

  // Once per cycle, away from the clock edge: check WB against what the
  // previous cycle retired, check this cycle's combinational outputs, then
  // advance the reference as if the coming edge happened.
  always @(negedge clk) begin
    slot_t   s [2];
    wb_exp_t nxt [2];
    logic    act [2], mis [2], memop [2], retire [2];
    logic    hold2, e_we, e_re;
    int      acc;
    logic [31:0] rd_val;
    logic [9:0]  e_corr;
    s[0] = cur1; s[1] = cur2;

    if (m_ready) begin
      for (int k = 0; k < 2; k++) begin
        logic [31:0] a_wd, a_alu; logic [4:0] a_wr; logic a_rw, a_jal;
        a_wd  = (k == 0) ? wd1 : wd2;
        a_alu = (k == 0) ? alu1_wb : alu2_wb;
        a_wr  = (k == 0) ? wr1 : wr2;
        a_rw  = (k == 0) ? rw1 : rw2;
        a_jal = (k == 0) ? jal1_wb : jal2_wb;
        if (m_zero) begin
          checkOutput($sformatf("rst_wd%0d", k+1), a_wd, 0);
          checkOutput($sformatf("rst_alu%0d", k+1), a_alu, 0);
          checkOutput($sformatf("rst_wr%0d", k+1), {27'b0, a_wr}, 0);
          checkOutput($sformatf("rst_rw%0d", k+1), {31'b0, a_rw}, 0);
          checkOutput($sformatf("rst_jal%0d", k+1), {31'b0, a_jal}, 0);
        end else begin
          checkOutput($sformatf("m_rw%0d", k+1), {31'b0, a_rw}, {31'b0, m_wb[k].rw});
          checkOutput($sformatf("m_jal%0d", k+1), {31'b0, a_jal}, {31'b0, m_wb[k].jal});
          if (m_wb[k].chk) checkOutput($sformatf("m_alu%0d", k+1), a_alu, m_wb[k].alu);
          if (m_wb[k].rw) begin
            checkOutput($sformatf("m_wd%0d", k+1), a_wd, m_wb[k].wd);
            checkOutput($sformatf("m_wr%0d", k+1), {27'b0, a_wr}, {27'b0, m_wb[k].wr});
          end
        end
      end
    end

    checkOutput("m_fwd1", fwd1, cur1.alu);
    checkOutput("m_fwd2", fwd2, cur2.alu);

    if (rst) begin
      checkOutput("m_rst_we", {31'b0, dmem_we}, 0);
      checkOutput("m_rst_re", {31'b0, dmem_re}, 0);
      checkOutput("m_rst_stall", {31'b0, mem_stall}, 0);
      checkOutput("m_rst_cor", {31'b0, correct_en}, 0);
      m_ready = 1'b1; m_zero = 1'b1; m_pend2 = 1'b0; m_squash = 1'b0;
    end else begin
      act[0]   = !m_pend2 && !m_squash;
      mis[0]   = act[0] && s[0].br && (s[0].tk != s[0].pr);
      act[1]   = !m_squash && !mis[0];
      memop[0] = act[0] && (s[0].re || s[0].we);
      memop[1] = act[1] && (s[1].re || s[1].we);
      hold2    = !m_pend2 && memop[0] && memop[1];
      mis[1]   = act[1] && !hold2 && s[1].br && (s[1].tk != s[1].pr);
      retire[0] = act[0];
      retire[1] = act[1] && !hold2;
      acc = memop[0] ? 0 : (memop[1] ? 1 : -1);
      e_we = (acc >= 0) && s[acc].we;
      e_re = (acc >= 0) && s[acc].re;
      e_corr = '0;
      if (mis[0]) e_corr = s[0].tk ? s[0].tgt : s[0].ra;
      else if (mis[1]) e_corr = s[1].tk ? s[1].tgt : s[1].ra;

      checkOutput("m_stall", {31'b0, mem_stall}, {31'b0, hold2});
      checkOutput("m_we", {31'b0, dmem_we}, {31'b0, e_we});
      checkOutput("m_re", {31'b0, dmem_re}, {31'b0, e_re});
      checkOutput("m_cor", {31'b0, correct_en}, {31'b0, mis[0] || mis[1]});
      checkOutput("m_fl1", {31'b0, flush_IFID}, {31'b0, mis[0] || mis[1]});
      checkOutput("m_fl2", {31'b0, flush_IDEX}, {31'b0, mis[0] || mis[1]});
      if (mis[0] || mis[1]) checkOutput("m_corr", {22'b0, correction}, {22'b0, e_corr});
      if (acc >= 0) begin
        checkOutput("m_addr", {22'b0, dmem_addr}, {22'b0, s[acc].alu[9:0]});
        if (e_we) checkOutput("m_wdata", dmem_wdata, s[acc].fb);
      end

      rd_val = (acc >= 0) ? ref_mem[s[acc].alu[9:0]] : 32'h0;
      for (int k = 0; k < 2; k++) begin
        nxt[k].chk = retire[k];
        nxt[k].rw  = retire[k] && s[k].rw;
        nxt[k].jal = retire[k] && s[k].jal;
        nxt[k].wr  = s[k].dest;
        nxt[k].alu = s[k].alu;
        if (s[k].jal) nxt[k].wd = {22'b0, s[k].ra};
        else if (s[k].m2r) nxt[k].wd = rd_val;
        else nxt[k].wd = s[k].alu;
      end
      if (e_we) ref_mem[s[acc].alu[9:0]] = s[acc].fb;
      m_wb[0] = nxt[0]; m_wb[1] = nxt[1];
      m_zero = 1'b0; m_pend2 = hold2; m_squash = mis[0] || mis[1];
    end
  end

  task automatic applyStimulus(input slot_t a, input slot_t b);
    @(posedge clk); #1;
    cur1 = a; cur2 = b;
  endtask

  task automatic sampleNeg();
    @(negedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin ram[i] = '0; ref_mem[i] = '0; end
    ram[16] = 32'hAB; ref_mem[16] = 32'hAB;
    m_wb[0] = '0; m_wb[1] = '0;
    cur1 = nop_s(); cur2 = nop_s();
    $display("[TB] start");

    repeat (2) @(posedge clk);
    sampleNeg();
    checkOutput("reset_rw1", {31'b0, rw1}, 0);
    checkOutput("reset_wd2", wd2, 0);
    checkOutput("reset_stall", {31'b0, mem_stall}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // lw in slot 1, add in slot 2: single memory op, no stall.
    applyStimulus(lw_s(32'h10, 5'd2), alu_s(32'd5, 5'd3));
    sampleNeg();
    checkOutput("t1_re", {31'b0, dmem_re}, 1);
    checkOutput("t1_addr", {22'b0, dmem_addr}, 32'h10);
    checkOutput("t1_stall", {31'b0, mem_stall}, 0);
    applyStimulus(nop_s(), nop_s());
    sampleNeg();
    checkOutput("t1_wd1", wd1, 32'hAB);
    checkOutput("t1_wd2", wd2, 32'd5);
    checkOutput("t1_wr2", {27'b0, wr2}, 32'd3);
    checkOutput("t1_rw1", {31'b0, rw1}, 1);
    checkOutput("t1_rw2", {31'b0, rw2}, 1);

    // sw then lw of the same word: serialised over two cycles.
    applyStimulus(sw_s(32'd4, 32'h55), lw_s(32'd4, 5'd6));
    sampleNeg();
    checkOutput("t2_we", {31'b0, dmem_we}, 1);
    checkOutput("t2_stall", {31'b0, mem_stall}, 1);
    sampleNeg();
    checkOutput("t2_re", {31'b0, dmem_re}, 1);
    checkOutput("t2_addr", {22'b0, dmem_addr}, 32'd4);
    checkOutput("t2_stall1", {31'b0, mem_stall}, 0);
    checkOutput("t2_rw2_split", {31'b0, rw2}, 0);
    applyStimulus(nop_s(), nop_s());
    sampleNeg();
    checkOutput("t2_wd2", wd2, 32'h55);
    checkOutput("t2_rw2", {31'b0, rw2}, 1);

    // Slot 1 mispredicted taken branch squashes the slot 2 store.
    applyStimulus(br_s(1'b1, 1'b0, 10'h05, 10'h2A), sw_s(32'd8, 32'h77));
    sampleNeg();
    checkOutput("t3_cor", {31'b0, correct_en}, 1);
    checkOutput("t3_corr", {22'b0, correction}, 32'h2A);
    checkOutput("t3_fl1", {31'b0, flush_IFID}, 1);
    checkOutput("t3_fl2", {31'b0, flush_IDEX}, 1);
    checkOutput("t3_we", {31'b0, dmem_we}, 0);
    applyStimulus(alu_s(32'h11, 5'd7), alu_s(32'h22, 5'd8));
    sampleNeg();
    checkOutput("t3_cor_next", {31'b0, correct_en}, 0);
    applyStimulus(nop_s(), nop_s());
    sampleNeg();
    checkOutput("t3_rw1", {31'b0, rw1}, 0);
    checkOutput("t3_rw2", {31'b0, rw2}, 0);
    checkOutput("t3_ram8", ram[8], 0);

    // Slot 2 mispredicted not-taken branch; older slot 1 still retires.
    applyStimulus(alu_s(32'd9, 5'd4), br_s(1'b0, 1'b1, 10'h13, 10'h30));
    sampleNeg();
    checkOutput("t4_cor", {31'b0, correct_en}, 1);
    checkOutput("t4_corr", {22'b0, correction}, 32'h13);
    applyStimulus(nop_s(), nop_s());
    sampleNeg();
    checkOutput("t4_wd1", wd1, 32'd9);
    checkOutput("t4_wr1", {27'b0, wr1}, 32'd4);
    checkOutput("t4_rw1", {31'b0, rw1}, 1);

    // jal writes the link value into r31.
    applyStimulus(jal_s(10'h07), nop_s());
    applyStimulus(nop_s(), nop_s());
    sampleNeg();
    checkOutput("t5_wd1", wd1, 32'd7);
    checkOutput("t5_jal1", {31'b0, jal1_wb}, 1);
    checkOutput("t5_wr1", {27'b0, wr1}, 32'd31);
    checkOutput("t5_rw1", {31'b0, rw1}, 1);

    // Reset while slot 2's store waits in SPLIT.
    applyStimulus(sw_s(32'd20, 32'h11), sw_s(32'd21, 32'h22));
    sampleNeg();
    checkOutput("t6_stall", {31'b0, mem_stall}, 1);
    @(posedge clk); #1; rst = 1'b1;
    sampleNeg();
    checkOutput("t6_we_rst", {31'b0, dmem_we}, 0);
    checkOutput("t6_stall_rst", {31'b0, mem_stall}, 0);
    @(posedge clk); #1;
    sampleNeg();
    checkOutput("t6_rw1", {31'b0, rw1}, 0);
    checkOutput("t6_wd1", wd1, 0);
    @(posedge clk); #1; rst = 1'b0;
    sampleNeg();
    checkOutput("t6_ram21", ram[21], 0);
    checkOutput("t6_run_stall", {31'b0, mem_stall}, 1);
    checkOutput("t6_run_addr", {22'b0, dmem_addr}, 32'd20);
    sampleNeg();
    checkOutput("t6_split_addr", {22'b0, dmem_addr}, 32'd21);
    applyStimulus(nop_s(), nop_s());
    sampleNeg();
    checkOutput("t6_ram21_done", ram[21], 32'h22);
    repeat (2) applyStimulus(nop_s(), nop_s());
    sampleNeg();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_unit.md
Name: mem_wb_unit

Overview:
Back end of the dual-issue pipeline. It consumes both EX/MEM slot bundles and drives the single shared data-memory port, serialising slots when both access memory. It holds the MEM/WB registers and produces the WB-stage write-back, forwarding and branch-correction signals that feed the front pipe. Slot 1 is always the older instruction.

Parameters:
DATA_W, 32, datapath width
PC_W, 10, instruction address width (return_addr, correction)
DMEM_AW, 10, data-memory word address width, taken from aluRes[DMEM_AW-1:0]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
aluRes1_MEM, aluRes2_MEM  in  DATA_W  ALU result per slot
forwardBRes1_MEM, forwardBRes2_MEM  in  DATA_W  store data per slot
MemReadEn{1,2}_MEM, MemWriteEn{1,2}_MEM, MemtoReg{1,2}_MEM, RegWriteEn{1,2}_MEM, jal{1,2}_MEM, Branch{1,2}_MEM, taken{1,2}_MEM, pred{1,2}_MEM  in  1 each  slot control; pred = predicted-taken
DestReg1_MEM, DestReg2_MEM  in  5  destination register
return_addr{1,2}_MEM, target{1,2}_MEM  in  PC_W  fall-through PC / branch target
dmem_rdata  in  DATA_W  read data, valid the cycle after dmem_re
dmem_addr  out  DMEM_AW;  dmem_wdata  out  DATA_W;  dmem_we, dmem_re  out  1
mem_stall  out  1  freeze all upstream stages and the EX/MEM registers
aluRes1_MEM_fwd, aluRes2_MEM_fwd  out  DATA_W  MEM-stage forwarding values
writeData1_WB, writeData2_WB, aluRes1_WB, aluRes2_WB  out  DATA_W
writeReg1_WB, writeReg2_WB  out  5;  regWrite1_WB, regWrite2_WB, jal1_WB, jal2_WB  out  1
correct_en, flush_IFID, flush_IDEX  out  1;  correction  out  PC_W

Behaviour:
- Reset (synchronous, rst=1 at posedge): FSM goes to RUN. squash_q=0. Every WB output is 0. Memory strobes, mem_stall and correct_en are 0.
- Slot is live when it is not squashed (see squash rules).
- Slot is a mem op when it is live and MemReadEn|MemWriteEn.
- FSM states are RUN and SPLIT.
- RUN, at most one slot is a mem op: that slot drives dmem_addr, dmem_wdata, dmem_we/dmem_re. Both slots advance to WB on the next edge. This is 1-cycle MEM latency.
- RUN, both slots are mem ops:
  - Slot 1 accesses memory and mem_stall=1.
  - Next edge: slot 1 moves to WB, slot 2's WB regWrite=0, and the FSM goes to SPLIT.
- SPLIT:
  - Slot 2 accesses memory using the held upstream inputs. mem_stall=0.
  - Next edge: slot 2 moves to WB, slot 1's WB regWrite=0, and the FSM returns to RUN.
- mem_stall is combinational. Upstream guarantees the inputs are stable while it is high.
- WB data per slot:
  - jal: {zero, return_addr}.
  - MemtoReg: dmem_rdata, sampled in WB.
  - Otherwise aluRes.
  - regWrite_WB = RegWriteEn & live.
- Misprediction: a slot mispredicts when it is live, Branch=1 and taken≠pred.
  - Slot 1 has priority.
  - correct_en=1, flush_IFID=1 and flush_IDEX=1 in the same cycle, combinationally.
  - correction = taken ? target : return_addr.
- Slot 1 mispredict squashes slot 2 in the same cycle: no memory access, no WB write, and no SPLIT even if both slots are mem ops.
- Any mispredict sets squash_q. On the next accepted cycle both slots are squashed (wrong-path EX/MEM contents); squash_q then clears. A mispredict during SPLIT (slot 2 branch) is legal.
- Squashed slots never assert dmem_we.
- Forwarding outputs pass aluRes straight through, unconditionally.
- Reset mid-SPLIT aborts slot 2's access. No write occurs on that edge.

Decomposition:
- Shared package: slot bundle field widths, FSM state encoding (RUN=0, SPLIT=1) and the link register constant 31.
- One natural sub-module, mem_wb_slot_reg. It is a per-slot MEM/WB register with data select, instantiated twice.

Test Plan:
- Slot 1 lw aluRes=0x10 and slot 2 add aluRes=5 to r3; mem[0x10]=0xAB. Expect dmem_re with addr 0x10 and no stall. Next cycle writeData1_WB=0xAB, writeData2_WB=5 and writeReg2_WB=3, both regWrite=1.
- Slot 1 sw 0x55 to addr 4 and slot 2 lw addr 4. Cycle 0: we=1, mem_stall=1. Cycle 1: re at addr 4, slot 1 WB with regWrite2_WB=0. Cycle 2: writeData2_WB=0x55.
- Slot 1 branch with taken=1, pred=0 and target=0x2A, slot 2 sw. Expect correct_en=1, correction=0x2A, both flushes=1 and dmem_we=0. Next-cycle inputs with RegWriteEn=1 must give regWrite_WB=0.
- Slot 2 branch with taken=0, pred=1 and return_addr=0x13, slot 1 add. Expect correction=0x13 and slot 1 WB intact.
- Slot 1 jal with return_addr=0x07 and DestReg=31. Expect writeData1_WB=7, jal1_WB=1, writeReg1_WB=31.
- Assert rst during SPLIT. Expect no dmem_we, all WB outputs 0, FSM in RUN and mem_stall=0.
